aes256_enc: RTL and testbench



---
 rtl/aes256_enc.sv | 160 ++++++++++++++++
 tb/tb_aes256_enc.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes256_enc.sv
// Iterative AES-256 encryptor: one round per clock, rolling 256-bit key schedule, fixed KEY.
// Build option AES256_ENC_ZEROIZE_EN clears encData on the start edge and on leaving DONE.
module aes256_enc #(
    parameter logic [255:0] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [15:0][7:0] plaintext,
    input  logic             addr,
    input  logic [7:0]       flags,
    output logic [15:0][7:0] encData,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    fsm_t         fsm, fsm_next;
    logic [31:0]  ctrl;
    logic [3:0]   round;
    logic [127:0] blk;
    logic [255:0] key_reg;
    logic         last;
    logic [127:0] round_out;
    logic [31:0]  sw_in, key_tmp;
    logic [31:0]  n0, n1, n2, n3;
    logic [7:0]   rcon;
    logic         unused_bits;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte b of the state lives at bits [127-8b -: 8]; b = row + 4*column.
    function automatic logic [127:0] aes_round(input logic [127:0] s_in,
                                               input logic [127:0] rk,
                                               input logic         final_round);
        logic [7:0]   sb [16];
        logic [7:0]   sr [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] r;
        r = '0;
        for (int b = 0; b < 16; b++) sb[b] = sbox(s_in[127 - 8 * b -: 8]);
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                sr[w + 4 * c] = sb[w + 4 * ((c + w) % 4)];
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4 * c];
            a1 = sr[4 * c + 1];
            a2 = sr[4 * c + 2];
            a3 = sr[4 * c + 3];
            if (final_round)
                r[127 - 32 * c -: 32] = {a0, a1, a2, a3};
            else
                r[127 - 32 * c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                         a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                         a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                         xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
        return r ^ rk;
    endfunction

    assign last        = (round == 4'd14);
    assign round_out   = aes_round(blk, key_reg[127:0], last);
    assign unused_bits = ^{flags[7:1], ctrl[31:1]};

    // key_reg holds w[4r-4..4r+3] during round r; odd rounds produce the RotWord/Rcon group.
    always_comb begin
        rcon    = 8'h01 << round[3:1];
        sw_in   = round[0] ? {key_reg[23:0], key_reg[31:24]} : key_reg[31:0];
        key_tmp = sub_word(sw_in) ^ (round[0] ? {rcon, 24'h0} : 32'h0);
        n0      = key_reg[255:224] ^ key_tmp;
        n1      = key_reg[223:192] ^ n0;
        n2      = key_reg[191:160] ^ n1;
        n3      = key_reg[159:128] ^ n2;
    end

    always_comb begin
        fsm_next = fsm;
        case (fsm)
            IDLE:    if (addr && ctrl[0]) fsm_next = RUN;
            RUN:     if (flags[0]) fsm_next = IDLE;
                     else if (last) fsm_next = DONE;
            DONE:    if (!addr) fsm_next = IDLE;
            default: fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetn) fsm <= IDLE;
        else        fsm <= fsm_next;
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            ctrl    <= '0;
            round   <= '0;
            blk     <= '0;
            key_reg <= '0;
            encData <= '0;
            done    <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (!addr) begin
                        ctrl <= plaintext[3:0];
                    end else if (ctrl[0]) begin
                        blk     <= plaintext ^ KEY[255:128];
                        key_reg <= KEY;
                        round   <= 4'd1;
                        done    <= 1'b0;
`ifdef AES256_ENC_ZEROIZE_EN
                        encData <= '0;
`endif
                    end
                end
                RUN: begin
                    if (!flags[0]) begin
                        blk     <= round_out;
                        key_reg <= {key_reg[127:0], n0, n1, n2, n3};
                        round   <= round + 4'd1;
                        if (last) begin
                            encData <= round_out;
                            done    <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!addr) begin
                        done <= 1'b0;
                        ctrl <= plaintext[3:0];
`ifdef AES256_ENC_ZEROIZE_EN
                        encData <= '0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes256_enc.sv
// Self-checking bench for aes256_enc: directed FIPS-197 C.3 scenarios plus random blocks
// checked against a table-free AES-256 model built from GF(2^8) arithmetic.
module tb_aes256_enc;

    localparam logic [255:0] TB_KEY  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         resetn;
    logic         addr;
    logic [7:0]   flags;
    logic [127:0] plaintext;
    logic [127:0] enc_data;
    logic         done;

    int total = 0;
    int bad   = 0;

    logic [7:0]   sb_ref [256];
    logic [31:0]  w_ref  [60];
    logic [127:0] last_ct;

    aes256_enc #(.KEY(TB_KEY)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .plaintext(plaintext),
        .addr     (addr),
        .flags    (flags),
        .encData  (enc_data),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = '0;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [31:0] sub_ref(input logic [31:0] w);
        return {sb_ref[w[31:24]], sb_ref[w[23:16]], sb_ref[w[15:8]], sb_ref[w[7:0]]};
    endfunction

    // S-box from multiplicative inverse + affine map; key expansion from the FIPS-197 recurrence.
    task automatic build_ref();
        logic [7:0]  inv, v, s;
        logic [31:0] t;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = 8'h63;
            v = inv;
            for (int k = 0; k < 5; k++) begin
                s ^= v;
                v = {v[6:0], v[7]};
            end
            sb_ref[x] = s;
        end
        for (int i = 0; i < 8; i++) w_ref[i] = TB_KEY[255 - 32 * i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w_ref[i - 1];
            if (i % 8 == 0)
                t = sub_ref({t[23:0], t[31:24]}) ^ {8'(1 << (i / 8 - 1)), 24'h0};
            else if (i % 8 == 4)
                t = sub_ref(t);
            w_ref[i] = w_ref[i - 8] ^ t;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [127:0] out;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r][c] = pt[127 - 8 * (r + 4 * c) -: 8] ^ w_ref[c][31 - 8 * r -: 8];
        for (int rnd = 1; rnd <= 14; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = sb_ref[s[r][(c + r) % 4]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    s[r][c] = (rnd == 14) ? t[r][c] :
                              gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r + 1) % 4][c]) ^
                              t[(r + 2) % 4][c] ^ t[(r + 3) % 4][c];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    s[r][c] ^= w_ref[4 * rnd + c][31 - 8 * r -: 8];
        end
        out = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                out[127 - 8 * (r + 4 * c) -: 8] = s[r][c];
        return out;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Control write (enable set, random upper bits), start, then a bounded wait for done.
    task automatic run_block(input string tag, input logic [127:0] pt, input logic [127:0] exp);
        int           cyc;
        logic [127:0] idle_exp;
`ifdef AES256_ENC_ZEROIZE_EN
        idle_exp = '0;
`else
        idle_exp = last_ct;
`endif
        addr      = 1'b0;
        plaintext = rand128() | 128'h1;
        tick();
        check({tag, " idle done"}, 128'(done), 128'd0);
        check({tag, " idle ct"}, enc_data, idle_exp);
        addr      = 1'b1;
        plaintext = pt;
        flags     = {7'($urandom()), 1'b0};
        tick();
        check({tag, " E0 ct"}, enc_data, idle_exp);
        plaintext = rand128();
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!done && cyc < 20);
        check({tag, " latency"}, 128'(cyc), 128'd14);
        check({tag, " ct"}, enc_data, exp);
        last_ct = exp;
    endtask

    initial begin
        logic [127:0] pt;
        logic [127:0] abort_exp;

        build_ref();
        resetn    = 1'b1;
        addr      = 1'b0;
        flags     = 8'h00;
        plaintext = '0;
        last_ct   = '0;
        tick();
        tick();
        check("reset done", 128'(done), 128'd0);
        check("reset ct", enc_data, 128'd0);
        resetn = 1'b0;
        check("model fips", aes_ref(FIPS_PT), FIPS_CT);

        // Enable still clear after reset: start requests are ignored.
        addr      = 1'b1;
        plaintext = FIPS_PT;
        for (int i = 0; i < 30; i++) begin
            tick();
            check("gate done", 128'(done), 128'd0);
            check("gate ct", enc_data, 128'd0);
        end

        // FIPS-197 C.3 with exact per-edge done profile and a long hold.
        addr      = 1'b0;
        plaintext = 128'h1;
        tick();
        addr      = 1'b1;
        plaintext = FIPS_PT;
        tick();
        check("E0 done", 128'(done), 128'd0);
        plaintext = rand128();
        for (int e = 1; e <= 13; e++) begin
            tick();
            check("run done", 128'(done), 128'd0);
        end
        tick();
        check("E14 done", 128'(done), 128'd1);
        check("E14 ct", enc_data, FIPS_CT);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold done", 128'(done), 128'd1);
            check("hold ct", enc_data, FIPS_CT);
        end
        last_ct = FIPS_CT;

        run_block("restart", FIPS_PT, FIPS_CT);

        // Abort at E5, then idle with addr=0 long enough that a missed abort would surface.
        addr      = 1'b0;
        plaintext = 128'h1;
        tick();
        addr      = 1'b1;
        plaintext = FIPS_PT;
        tick();
`ifdef AES256_ENC_ZEROIZE_EN
        abort_exp = '0;
`else
        abort_exp = FIPS_CT;
`endif
        repeat (4) tick();
        flags = 8'h01;
        tick();
        flags     = 8'h00;
        addr      = 1'b0;
        plaintext = 128'h1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("abort done", 128'(done), 128'd0);
            check("abort ct", enc_data, abort_exp);
        end
        last_ct = abort_exp;
        run_block("after abort", FIPS_PT, FIPS_CT);

        // Reset at E7 clears outputs and ctrl; a fresh control write is then required.
        addr      = 1'b0;
        plaintext = 128'h1;
        tick();
        addr      = 1'b1;
        plaintext = FIPS_PT;
        tick();
        repeat (6) tick();
        resetn = 1'b1;
        tick();
        resetn = 1'b0;
        check("midreset done", 128'(done), 128'd0);
        check("midreset ct", enc_data, 128'd0);
        last_ct = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("post reset gate", 128'(done), 128'd0);
        end
        run_block("after reset", FIPS_PT, FIPS_CT);

        for (int n = 0; n < 8; n++) begin
            pt = rand128();
            run_block("random", pt, aes_ref(pt));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
